// File: rtl/csr_wide_bridge.sv
// csr_wide_bridge: 32-bit CPU register bus to 128-bit wide CSR initiator.
// Optional macro CSR_BRIDGE_AUTOCOMMIT_EN: a staging word 3 write in IDLE also commits.
module csr_wide_bridge #(
  parameter int unsigned RD_LAT      = 2,
  parameter logic [3:0]  PERIPH_ADDR = 4'd0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   bus_addr,
  input  logic         bus_we,
  input  logic         bus_re,
  input  logic [31:0]  bus_wdata,
  output logic [31:0]  bus_rdata,
  output logic         bus_ack,
  output logic         csr2_we,
  output logic [127:0] csr2_wdata,
  output logic [3:0]   csr2_addr,
  input  logic [127:0] csr2_rdata,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT, CAPTURE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(RD_LAT - 1);

  state_t             state_q;
  logic [3:0]         waitCnt_q;
  logic [3:0][31:0]   stage_q;
  logic [3:0][31:0]   snap_q;
  logic [7:0]         commitCnt_q;
  logic               err_q;
  logic               busy_q;
  logic               csr2We_q;
  logic [127:0]       csr2Wdata_q;
  logic [3:0]         csr2Addr_q;
  logic               busAck_q;
  logic [31:0]        busRdata_q;

  logic [31:0]        readData_d;
  logic [31:0]        statusWord;
  logic [127:0]       commitData;
  logic               stageWr;
  logic               ctrlWr;
  logic               clrReq;
  logic               autoReq;
  logic               startReq;

`ifdef CSR_BRIDGE_AUTOCOMMIT_EN
  localparam logic AUTO_BIT = 1'b1;
  assign autoReq = bus_we && (bus_addr == 4'd3);
`else
  localparam logic AUTO_BIT = 1'b0;
  assign autoReq = 1'b0;
`endif

  assign stageWr  = bus_we && (bus_addr[3:2] == 2'b00);
  assign ctrlWr   = bus_we && (bus_addr == 4'd4);
  assign clrReq   = ctrlWr && bus_wdata[1];
  assign startReq = (ctrlWr && bus_wdata[0]) || autoReq;

  // An auto-commit must carry the word 3 value being written this very cycle.
  assign commitData = autoReq ? {bus_wdata, stage_q[2:0]} : stage_q;

  assign statusWord = {16'd0, commitCnt_q, 5'd0, AUTO_BIT, err_q, busy_q};

  always_comb begin
    readData_d = '0;
    case (bus_addr)
      4'd0, 4'd1, 4'd2, 4'd3:   readData_d = stage_q[bus_addr[1:0]];
      4'd5:                     readData_d = statusWord;
      4'd8, 4'd9, 4'd10, 4'd11: readData_d = snap_q[bus_addr[1:0]];
      default:                  readData_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      waitCnt_q   <= '0;
      stage_q     <= '0;
      snap_q      <= '0;
      commitCnt_q <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      csr2We_q    <= 1'b0;
      csr2Wdata_q <= '0;
      csr2Addr_q  <= '0;
      busAck_q    <= 1'b0;
      busRdata_q  <= '0;
    end else begin
      busAck_q   <= bus_we | bus_re;
      busRdata_q <= (bus_re && !bus_we) ? readData_d : '0;
      csr2We_q   <= 1'b0;

      if (stageWr) stage_q[bus_addr[1:0]] <= bus_wdata;

      // A commit request arriving while a transfer is in flight is dropped and flagged.
      if (clrReq) err_q <= 1'b0;
      if (startReq && busy_q) err_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (startReq) begin
            csr2Wdata_q <= commitData;
            csr2Addr_q  <= PERIPH_ADDR;
            csr2We_q    <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= PULSE;
          end
        end
        PULSE: begin
          waitCnt_q <= WAIT_INIT;
          state_q   <= (RD_LAT == 1) ? CAPTURE : WAIT;
        end
        WAIT: begin
          waitCnt_q <= waitCnt_q - 4'd1;
          if (waitCnt_q <= 4'd1) state_q <= CAPTURE;
        end
        CAPTURE: begin
          snap_q      <= csr2_rdata;
          commitCnt_q <= commitCnt_q + 8'd1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_rdata  = busRdata_q;
  assign bus_ack    = busAck_q;
  assign csr2_we    = csr2We_q;
  assign csr2_wdata = csr2Wdata_q;
  assign csr2_addr  = csr2Addr_q;
  assign busy       = busy_q;

endmodule

// File: doc/csr_wide_bridge.md
Name: csr_wide_bridge

Overview:
Initiator side of the 128-bit wide CSR peripheral interface (csr2_we / csr2_wdata / csr2_addr / csr2_rdata). It bridges a 32-bit CPU register bus to that interface:
- CPU fills four 32-bit staging words, then issues a commit.
- FSM presents the 128-bit word with a single-cycle csr2_we pulse.
- After the peripheral's read latency, FSM captures csr2_rdata into a snapshot the CPU reads back 32 bits at a time.

Parameters:
RD_LAT, 2, cycles from csr2_we pulse to csr2_rdata reflecting the write (legal 1..15).
PERIPH_ADDR, 4'd0, constant value driven on csr2_addr during commit.

Ports:
clk  input  1  system clock, all logic rising-edge.
rst_n  input  1  synchronous active-low reset.
bus_addr  input  4  CPU word address.
bus_we  input  1  CPU write strobe, one cycle.
bus_re  input  1  CPU read strobe, one cycle.
bus_wdata  input  32  CPU write data.
bus_rdata  output  32  CPU read data, valid with bus_ack.
bus_ack  output  1  one-cycle acknowledge.
csr2_we  output  1  write pulse to peripheral.
csr2_wdata  output  128  word presented to peripheral.
csr2_addr  output  4  peripheral address.
csr2_rdata  input  128  peripheral read-back word (registered in peripheral).
busy  output  1  FSM not IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all state:
  - Outputs: bus_rdata=0, bus_ack=0, csr2_we=0, csr2_wdata=0, csr2_addr=0, busy=0.
  - Staging, snapshot, commit counter and err flag all 0; FSM to IDLE.
  - Reset mid-commit aborts with no capture.
- Address map:
  - 0-3: staging word n, R/W; word n maps to bits [32n+31:32n].
  - 4: CTRL, write-only. bit0=COMMIT; bit1=CLR_ERR. Reads return 0.
  - 5: STATUS, RO. bit0=busy; bit1=err; bits[15:8]=commit count, mod 256.
  - 8-11: snapshot word n, RO.
  - Unmapped: writes ignored, reads 0, still acked.
- Bus handshake:
  - bus_ack asserts exactly one cycle after every bus_we or bus_re.
  - bus_rdata is registered and valid in the same cycle as bus_ack.
  - If bus_we and bus_re are asserted together, the write wins; ack once; bus_rdata=0.
- Staging writes are accepted in any state. csr2_wdata changes only at commit, so staging writes during busy do not disturb an in-flight transfer.
- FSM states:
  - IDLE: COMMIT write → csr2_wdata<=staging, csr2_addr<=PERIPH_ADDR, go to PULSE.
  - PULSE: csr2_we=1 for exactly this cycle; load wait counter with RD_LAT-1; go to WAIT.
  - WAIT: decrement counter; at 0 go to CAPTURE.
  - CAPTURE: snapshot<=csr2_rdata; commit count +1; go to IDLE.
  - Timing: csr2_we is high in cycle T+1 after the CTRL write at T; capture occurs at cycle T+1+RD_LAT.
- busy is high in PULSE, WAIT and CAPTURE.
- COMMIT written while busy: ignored, err<=1 (sticky).
- CLR_ERR clears err. If COMMIT and CLR_ERR are in the same write in IDLE, both actions take effect.
- Snapshot reads during busy return the previous snapshot, never a partial update.
- csr2_wdata and csr2_addr hold their values after capture until the next commit.
- Commit count wraps 255→0.

Optional Feature:
CSR_BRIDGE_AUTOCOMMIT_EN
- Defined: a write to staging word 3 in IDLE also triggers COMMIT, using the just-written word 3 value. In that case, on a busy write to word 3, the data is stored and err is set. STATUS bit2 reads 1.
- Undefined: only CTRL.COMMIT triggers a transfer; STATUS bit2 reads 0.

Test Plan:
Bench peripheral model: registered; on csr2_we latches w0..w3; next cycle drives rdata[31:0]=w1+256, rdata[63:32]=w0, rdata[95:64]=w2, rdata[127:96]=w3 (RD_LAT=2).
1. Write staging 0-3 = 0x11,0x22,0x33,0x44; CTRL=1 → csr2_we high exactly 1 cycle with csr2_wdata=0x00000044_00000033_00000022_00000011; snapshot words 8-11 read 0x122,0x11,0x33,0x44; STATUS=0x0100.
2. Commit, then CTRL=1 again 1 cycle later while busy → one csr2_we pulse only; STATUS bit1=1. CTRL=2 → bit1=0.
3. Write staging 0 = 0xDEAD during WAIT → transfer unaffected; snapshot word 9 reads 0x11; next commit gives word 9=0xDEAD.
4. 256 commits → count reads 0; simultaneous bus_we+bus_re to addr 0 → single ack, write applied.
5. rst_n=0 during WAIT → busy=0, csr2_wdata=0, snapshot 0, no capture afterwards.
6. With CSR_BRIDGE_AUTOCOMMIT_EN, write words 0-3 only, no CTRL write → csr2_we pulses 1 cycle after the word-3 write; STATUS bit2=1.
